// File: rtl/div3_pkg.sv
`default_nettype none
// ============================================================================
// Module      : div3_pkg
// Description : Shared constants, FSM state encoding and CHUNK legality check
//               for the divide-by-3 datapath family (divider, reconstruction
//               block and their benches).
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package div3_pkg;

    localparam int DIVISOR = 3;
    localparam int X_W     = 32;
    localparam int Q_W     = 31;
    localparam int R_W     = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    // CHUNK must divide the 32-bit word into a power-of-two number of beats.
    function automatic bit chunk_legal(input int chunk);
        return (chunk == 4) || (chunk == 8) || (chunk == 16) || (chunk == 32);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mul_32_3_if.sv
`default_nettype none
// ============================================================================
// Module      : mul_32_3_if
// Description : Operand/result handshake bundle of the 3*Q+R reconstruction
//               block.
// Ports       : in_valid/in_ready/Q/R  - operand channel (master -> slave)
//               out_valid/out_ready/X/err_res/err_ovf - result channel
// Revision    : 1.0 - initial release
// ============================================================================
interface mul_32_3_if;

    logic                       in_valid;
    logic                       in_ready;
    logic [div3_pkg::Q_W-1:0]   Q;
    logic [div3_pkg::R_W-1:0]   R;
    logic                       out_valid;
    logic                       out_ready;
    logic [div3_pkg::X_W-1:0]   X;
    logic                       err_res;
    logic                       err_ovf;

    // Producer of operands / consumer of results.
    modport master (
        output in_valid, Q, R, out_ready,
        input  in_ready, out_valid, X, err_res, err_ovf
    );

    // The reconstruction block itself.
    modport slave (
        input  in_valid, Q, R, out_ready,
        output in_ready, out_valid, X, err_res, err_ovf
    );

endinterface
`default_nettype wire

// File: rtl/mul_32_3_chunk_add3.sv
`default_nettype none
// ============================================================================
// Module      : chunk_add3
// Description : Combinational CHUNK-bit add of two operands plus a 2-bit
//               carry-in. The carry-in can be up to 3, so the carry-out needs
//               two bits as well.
// Ports       : a_i, b_i  - CHUNK-bit operands
//               cin_i     - 2-bit carry-in
//               sum_o     - low CHUNK bits of the sum
//               cout_o    - upper 2 bits of the sum
// Revision    : 1.0 - initial release
// ============================================================================
module chunk_add3 #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic [1:0]       cin_i,
    output logic [CHUNK-1:0] sum_o,
    output logic [1:0]       cout_o
);

    logic [CHUNK+1:0] w_total;

    assign w_total         = {2'b00, a_i} + {2'b00, b_i} + {{CHUNK{1'b0}}, cin_i};
    assign {cout_o, sum_o} = w_total;

endmodule
`default_nettype wire

// File: rtl/mul_32_3.sv
`default_nettype none
// ============================================================================
// Module      : mul_32_3
// Description : Rebuilds X = 3*Q + R digit-serially, CHUNK bits per beat.
//               A holds Q and B holds 2*Q; each beat adds their low CHUNK
//               bits plus the running carry. The residue R seeds the carry.
// Ports       : clk    - clock, rising edge
//               rst_n  - asynchronous active-low reset
//               bus    - operand/result handshake (slave side)
// Revision    : 1.0 - initial release
// ============================================================================
module mul_32_3
    import div3_pkg::*;
#(
    parameter int CHUNK = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    mul_32_3_if.slave  bus
);

    localparam int                BEATS     = X_W / CHUNK;
    localparam int                CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);

    if (!chunk_legal(CHUNK)) begin : g_bad_chunk
        $error("mul_32_3: CHUNK must be 4, 8, 16 or 32");
    end

    state_e             state_q,     state_d;
    logic [X_W-1:0]     a_q,         a_d;
    logic [X_W-1:0]     b_q,         b_d;
    logic [X_W-1:0]     x_q,         x_d;
    logic [R_W-1:0]     carry_q,     carry_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic               err_res_q,   err_res_d;
    logic               err_ovf_q,   err_ovf_d;
    logic               out_valid_q, out_valid_d;

    logic [CHUNK-1:0]   w_sum;
    logic [1:0]         w_cout;

    chunk_add3 #(
        .CHUNK (CHUNK)
    ) u_add (
        .a_i    (a_q[CHUNK-1:0]),
        .b_i    (b_q[CHUNK-1:0]),
        .cin_i  (carry_q),
        .sum_o  (w_sum),
        .cout_o (w_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            x_q         <= '0;
            carry_q     <= '0;
            cnt_q       <= '0;
            err_res_q   <= 1'b0;
            err_ovf_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            x_q         <= x_d;
            carry_q     <= carry_d;
            cnt_q       <= cnt_d;
            err_res_q   <= err_res_d;
            err_ovf_q   <= err_ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        x_d         = x_q;
        carry_d     = carry_q;
        cnt_d       = cnt_q;
        err_res_d   = err_res_q;
        err_ovf_d   = err_ovf_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d       = {1'b0, bus.Q};
                    b_d       = {bus.Q, 1'b0};
                    // R == 3 is still added; it is only flagged.
                    carry_d   = bus.R;
                    err_res_d = (bus.R == R_W'(DIVISOR));
                    err_ovf_d = 1'b0;
                    x_d       = '0;
                    cnt_d     = '0;
                    state_d   = CALC;
                end
            end
            CALC: begin
                x_d[int'(cnt_q) * CHUNK +: CHUNK] = w_sum;
                carry_d = w_cout;
                a_d     = a_q >> CHUNK;
                b_d     = b_q >> CHUNK;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BEAT) begin
                    // Any carry out of the top beat means 3Q+R did not fit.
                    err_ovf_d   = (w_cout != 2'b00);
                    cnt_d       = '0;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.X         = x_q;
    assign bus.err_res   = err_res_q;
    assign bus.err_ovf   = err_ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_32_3.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_32_3
// Description : Self-checking bench for mul_32_3: directed vector table and
//               corner sequences on a CHUNK=8 instance, then a randomised
//               sweep on one instance per legal CHUNK against 3*Q+R.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mul_32_3;
    import div3_pkg::*;

    localparam int N_SWEEP = 1500;

    typedef struct {
        logic [30:0] q;
        logic [1:0]  r;
        logic [31:0] x;
        logic        res;
        logic        ovf;
    } vec_t;

    typedef struct {
        logic [31:0] x;
        logic        res;
        logic        ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic rst_sw_n;
    logic sweep_go;
    int   sw_finished = 0;
    int   n_pass = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    mul_32_3_if dif ();

    mul_32_3 #(.CHUNK(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dif)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference: plain arithmetic on the full-width value.
    function automatic exp_t ref_model(input logic [30:0] q, input logic [1:0] r);
        logic [63:0] full;
        exp_t e;
        full  = 64'(q) * 64'd3 + 64'(r);
        e.x   = full[31:0];
        e.ovf = (full >= 64'h1_0000_0000);
        e.res = (r == 2'd3);
        return e;
    endfunction

    // One transaction on the CHUNK=8 instance with out_ready held high.
    task automatic do_txn(input logic [30:0] q, input logic [1:0] r,
                          output logic [31:0] x, output logic res, output logic ovf,
                          output int lat);
        @(negedge clk);
        dif.Q = q; dif.R = r; dif.in_valid = 1'b1;
        @(negedge clk);
        dif.in_valid = 1'b0;
        lat = 1;
        while (!dif.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        x = dif.X; res = dif.err_res; ovf = dif.err_ovf;
        @(negedge clk);
        check("drop_after_hs", 64'({dif.out_valid, dif.in_ready}), 64'(2'b01));
    endtask

    vec_t vecs [8];

    initial begin
        logic [31:0] x, x0;
        logic        res, ovf, bad;
        int          lat, cnt;

        vecs[0] = '{q: 31'h12345678, r: 2'd2, x: 32'h369D036A, res: 1'b0, ovf: 1'b0};
        vecs[1] = '{q: 31'h55555555, r: 2'd0, x: 32'hFFFFFFFF, res: 1'b0, ovf: 1'b0};
        vecs[2] = '{q: 31'h55555555, r: 2'd1, x: 32'h00000000, res: 1'b0, ovf: 1'b1};
        vecs[3] = '{q: 31'h00000001, r: 2'd3, x: 32'h00000006, res: 1'b1, ovf: 1'b0};
        vecs[4] = '{q: 31'h00000000, r: 2'd0, x: 32'h00000000, res: 1'b0, ovf: 1'b0};
        vecs[5] = '{q: 31'h7FFFFFFF, r: 2'd2, x: 32'h7FFFFFFF, res: 1'b0, ovf: 1'b1};
        vecs[6] = '{q: 31'h55555556, r: 2'd0, x: 32'h00000002, res: 1'b0, ovf: 1'b1};
        vecs[7] = '{q: 31'h00000007, r: 2'd1, x: 32'h00000016, res: 1'b0, ovf: 1'b0};

        dif.in_valid = 1'b0; dif.Q = '0; dif.R = '0; dif.out_ready = 1'b1;
        rst_n = 1'b0; rst_sw_n = 1'b0; sweep_go = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_ctrl", 64'({dif.in_ready, dif.out_valid, dif.err_res, dif.err_ovf}), 64'(4'b1000));
        check("reset_x", 64'(dif.X), 64'd0);
        rst_n = 1'b1; rst_sw_n = 1'b1;

        // Directed vector table.
        for (int i = 0; i < 8; i++) begin
            do_txn(vecs[i].q, vecs[i].r, x, res, ovf, lat);
            check("vec_latency", 64'(lat), 64'd5);
            check("vec_x", 64'(x), 64'(vecs[i].x));
            check("vec_err_res", 64'(res), 64'(vecs[i].res));
            check("vec_err_ovf", 64'(ovf), 64'(vecs[i].ovf));
        end

        // Throughput: BEATS+2 cycles between accept opportunities.
        @(negedge clk);
        dif.Q = 31'd5; dif.R = 2'd0; dif.in_valid = 1'b1;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!dif.in_ready && cnt < 40);
        dif.in_valid = 1'b0;
        check("throughput", 64'(cnt), 64'd6);

        // Backpressure: result held for 10 cycles, new offer ignored.
        dif.out_ready = 1'b0;
        @(negedge clk);
        dif.Q = 31'h12345678; dif.R = 2'd2; dif.in_valid = 1'b1;
        @(negedge clk);
        dif.in_valid = 1'b0;
        lat = 1;
        while (!dif.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        x0 = dif.X;
        bad = 1'b0;
        dif.Q = 31'd3; dif.R = 2'd0; dif.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (dif.X !== x0 || dif.out_valid !== 1'b1 || dif.in_ready !== 1'b0 ||
                dif.err_res !== 1'b0 || dif.err_ovf !== 1'b0) bad = 1'b1;
        end
        check("bp_stable", 64'(bad), 64'd0);
        check("bp_x", 64'(dif.X), 64'h369D036A);
        dif.out_ready = 1'b1;
        @(negedge clk);
        check("bp_release", 64'({dif.out_valid, dif.in_ready}), 64'(2'b01));
        @(negedge clk);
        dif.in_valid = 1'b0;
        check("bp_accept_next", 64'(dif.in_ready), 64'd0);
        lat = 1;
        while (!dif.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("bp_next_latency", 64'(lat), 64'd5);
        check("bp_next_x", 64'(dif.X), 64'd9);
        @(negedge clk);

        // Asynchronous reset during the second CALC beat.
        @(negedge clk);
        dif.Q = 31'h12345678; dif.R = 2'd2; dif.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        dif.in_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_ctrl", 64'({dif.in_ready, dif.out_valid, dif.err_res, dif.err_ovf}), 64'(4'b1000));
        check("abort_x", 64'(dif.X), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_txn(31'd7, 2'd1, x, res, ovf, lat);
        check("post_abort_x", 64'(x), 64'd22);
        check("post_abort_flags", 64'({res, ovf}), 64'd0);

        // Randomised sweep over all legal CHUNK values.
        sweep_go = 1'b1;
        for (int k = 0; k < 60000 && sw_finished < 4; k++) @(negedge clk);
        check("sweep_complete", 64'(sw_finished), 64'd4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_sweep
        mul_32_3_if sif ();

        mul_32_3 #(.CHUNK(4 << gi)) u_dut (
            .clk   (clk),
            .rst_n (rst_sw_n),
            .bus   (sif)
        );

        initial begin
            logic [30:0] q;
            logic [1:0]  r;
            exp_t        e;
            int          w;
            sif.in_valid = 1'b0; sif.Q = '0; sif.R = '0; sif.out_ready = 1'b0;
            wait (sweep_go);
            for (int n = 0; n < N_SWEEP; n++) begin
                if (n % 8 == 0) q = 31'(32'h5555_5553 + $urandom_range(0, 4));
                else            q = 31'($urandom);
                r = 2'($urandom_range(0, 3));
                e = ref_model(q, r);
                @(negedge clk);
                sif.Q = q; sif.R = r; sif.in_valid = 1'b1; sif.out_ready = 1'b0;
                @(negedge clk);
                sif.in_valid = 1'b0;
                w = 0;
                while (!sif.out_valid && w < 60) begin
                    @(negedge clk);
                    w++;
                end
                repeat ($urandom_range(0, 2)) @(negedge clk);
                check("sweep_valid", 64'(sif.out_valid), 64'd1);
                check("sweep_x", 64'(sif.X), 64'(e.x));
                check("sweep_flags", 64'({sif.err_res, sif.err_ovf}), 64'({e.res, e.ovf}));
                if (!sif.err_ovf && !sif.err_res)
                    check("sweep_residue", 64'(sif.X % 32'd3), 64'(r));
                sif.out_ready = 1'b1;
                @(negedge clk);
                sif.out_ready = 1'b0;
            end
            sw_finished++;
        end
    end

endmodule
`default_nettype wire
